// File: rtl/pipe_ctrl_pkg.sv
// Shared types and idCtrl/exCtrl field positions for the pipeline hazard controller
// and the decoder that merges its selects.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} ctrlState_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rW;
        logic       regWr;
        logic       load;
    } stageRec_t;

    localparam stageRec_t BUBBLE = '0;

    localparam int EXMEMIDA = 1;
    localparam int EXMEMIDB = 2;
    localparam int EXMEMEXA = 3;
    localparam int EXMEMEXB = 4;
    localparam int MEMWBEXA = 5;
    localparam int MEMWBEXB = 6;

    // Register 0 is hard-wired, so it never produces a hazard.
    function automatic logic stageMatch(input stageRec_t s, input logic [4:0] src);
        return s.valid && s.regWr && (s.rW == src) && (src != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against the EX and MEM shadows and derives
// that source's forwarding selects.
module hazard_match import pipe_ctrl_pkg::*; (
    input  logic [4:0]                  src,
    input  logic                        useSrc,
    input  logic [$bits(stageRec_t)-1:0] exStage,
    input  logic [$bits(stageRec_t)-1:0] memStage,
    output logic                        exHit,
    output logic                        memHit,
    output logic                        exMemEx,
    output logic                        memWbEx,
    output logic                        exMemId
);

    stageRec_t ex;
    stageRec_t mem;

    assign ex  = stageRec_t'(exStage);
    assign mem = stageRec_t'(memStage);

    assign exHit  = stageMatch(ex, src);
    assign memHit = stageMatch(mem, src);

    // Nearest producer wins; loads have no result until WB.
    assign exMemEx = useSrc && exHit && !ex.load;
    assign memWbEx = useSrc && memHit && !exMemEx;
    assign exMemId = useSrc && memHit && !mem.load;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Destination-register shadow of EX/MEM/WB driving forwarding selects, stalls,
// the multiply interlock and the end-of-program drain.
module pipeline_hazard_controller import pipe_ctrl_pkg::*; #(
    parameter int MUL_LAT   = 2,
    parameter int DRAIN_CYC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rS1,
    input  logic [4:0] rS2,
    input  logic       useS1,
    input  logic       useS2,
    input  logic [4:0] rWId,
    input  logic       regWrId,
    input  logic       loadId,
    input  logic       branchId,
    input  logic       mulId,
    input  logic       haltId,
    output logic       stall,
    output logic       ifIdWr,
    output logic       exMemIdA,
    output logic       exMemIdB,
    output logic       exMemExA,
    output logic       exMemExB,
    output logic       memWbExA,
    output logic       memWbExB,
    output logic       endProgram
);

    stageRec_t  exStage, memStage, wbStage, idRec;
    ctrlState_t state, stateNext;
    logic [2:0] mulCnt;
    logic [7:0] drainCnt, drainNext;
    logic       exHit1, memHit1, exHit2, memHit2;
    logic       loadUse, branchStall;
    logic       unusedWb;

    hazard_match matchS1 (
        .src(rS1), .useSrc(useS1), .exStage(exStage), .memStage(memStage),
        .exHit(exHit1), .memHit(memHit1),
        .exMemEx(exMemExA), .memWbEx(memWbExA), .exMemId(exMemIdA)
    );

    hazard_match matchS2 (
        .src(rS2), .useSrc(useS2), .exStage(exStage), .memStage(memStage),
        .exHit(exHit2), .memHit(memHit2),
        .exMemEx(exMemExB), .memWbEx(memWbExB), .exMemId(exMemIdB)
    );

    // WB is tracked for completeness; the register file writes on ~clk so ID sees it directly.
    assign unusedWb = ^{wbStage, memHit2};

    assign idRec       = {1'b1, rWId, regWrId, loadId};
    assign loadUse     = exStage.load && ((useS1 && exHit1) || (useS2 && exHit2));
    assign branchStall = branchId && (exHit1 || (memHit1 && memStage.load));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exStage  <= BUBBLE;
            memStage <= BUBBLE;
            wbStage  <= BUBBLE;
        end else begin
            exStage  <= stall ? BUBBLE : idRec;
            memStage <= exStage;
            wbStage  <= memStage;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mulCnt <= 3'd0;
        else if (mulCnt != 3'd0)
            mulCnt <= mulCnt - 3'd1;
        else if (!stall && mulId)
            mulCnt <= 3'(MUL_LAT - 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            drainCnt <= 8'd0;
        end else begin
            state    <= stateNext;
            drainCnt <= drainNext;
        end
    end

    always_comb begin
        stateNext  = state;
        drainNext  = drainCnt;
        endProgram = 1'b0;
        stall      = loadUse || branchStall || (mulCnt != 3'd0);
        case (state)
            RUN: begin
                if (!stall && haltId) begin
                    stateNext = DRAIN;
                    drainNext = 8'(DRAIN_CYC - 1);
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (drainCnt == 8'd0) begin
                    endProgram = 1'b1;
                    stateNext  = HALTED;
                end else begin
                    drainNext = drainCnt - 8'd1;
                end
            end
            HALTED: stall = 1'b1;
            default: stateNext = RUN;
        endcase
        ifIdWr = !stall;
    end

endmodule
